// File: rtl/fft16_bfly_sched.sv
// Butterfly sequencer for the 16-point radix-2 DIT CORDIC FFT: read/twiddle issue, delayed write-back.
// Optional build macro FFT16_INVERSE_EN adds an 'inverse' input that selects positive (IFFT) twiddle angles.
module fft16_bfly_sched #(
    parameter int BF_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
`ifdef FFT16_INVERSE_EN
    input  logic        inverse,
`endif
    output logic        busy,
    output logic        done,
    output logic [1:0]  stage,
    output logic        rd_en,
    output logic [3:0]  rd_addr_a,
    output logic [3:0]  rd_addr_b,
    output logic [2:0]  tw_idx,
    output logic [31:0] zangle,
    output logic        wr_en,
    output logic [3:0]  wr_addr_a,
    output logic [3:0]  wr_addr_b
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  k_reg, k_next;
    logic [1:0]  stage_cnt_reg, stage_cnt_next;
    logic [3:0]  drain_reg, drain_next;
`ifdef FFT16_INVERSE_EN
    logic        inv_reg, inv_next;
`endif

    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [1:0]  stage_reg, stage_next;
    logic        rd_en_reg, rd_en_next;
    logic [3:0]  rd_a_reg, rd_a_next;
    logic [3:0]  rd_b_reg, rd_b_next;
    logic [2:0]  tw_reg, tw_next;
    logic [31:0] zangle_reg, zangle_next;

    logic [3:0]  span, pos, grp, addr_a, addr_b, tw_wide;
    logic [2:0]  grp_shift;
    logic [31:0] angle_mag;

    // Sequencing FSM: state and loop counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            k_reg         <= 3'd0;
            stage_cnt_reg <= 2'd0;
            drain_reg     <= 4'd0;
`ifdef FFT16_INVERSE_EN
            inv_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            stage_cnt_reg <= stage_cnt_next;
            drain_reg     <= drain_next;
`ifdef FFT16_INVERSE_EN
            inv_reg       <= inv_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        stage_cnt_next = stage_cnt_reg;
        drain_next     = drain_reg;
`ifdef FFT16_INVERSE_EN
        inv_next       = inv_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = RUN;
                    k_next         = 3'd0;
                    stage_cnt_next = 2'd0;
`ifdef FFT16_INVERSE_EN
                    inv_next       = inverse;
`endif
                end
            end
            RUN: begin
                k_next = k_reg + 3'd1;
                if (k_reg == 3'd7) begin
                    state_next = DRAIN;
                    drain_next = 4'(BF_LAT - 1);
                end
            end
            DRAIN: begin
                // Counts down to zero, giving exactly BF_LAT idle issue slots
                if (drain_reg == 4'd0) begin
                    if (stage_cnt_reg == 2'd3) begin
                        state_next = DONE;
                    end else begin
                        state_next     = RUN;
                        stage_cnt_next = stage_cnt_reg + 2'd1;
                        k_next         = 3'd0;
                    end
                end else begin
                    drain_next = drain_reg - 4'd1;
                end
            end
            DONE: begin
                state_next     = IDLE;
                stage_cnt_next = 2'd0;
            end
            default: state_next = IDLE;
        endcase
    end

    // Butterfly address and twiddle generation for (stage, k)
    always_comb begin
        span      = 4'd1 << stage_cnt_reg;
        pos       = {1'b0, k_reg} & (span - 4'd1);
        grp       = {1'b0, k_reg} >> stage_cnt_reg;
        grp_shift = {1'b0, stage_cnt_reg} + 3'd1;
        addr_a    = (grp << grp_shift) | pos;
        addr_b    = addr_a + span;
        tw_wide   = pos << (2'd3 - stage_cnt_reg);
        angle_mag = {1'b0, tw_wide[2:0], 28'd0};
    end

    always_comb begin
        busy_next   = (state_reg == RUN) || (state_reg == DRAIN);
        done_next   = (state_reg == DONE);
        stage_next  = stage_cnt_reg;
        rd_en_next  = (state_reg == RUN);
        rd_a_next   = 4'd0;
        rd_b_next   = 4'd0;
        tw_next     = 3'd0;
        zangle_next = 32'd0;
        if (state_reg == RUN) begin
            rd_a_next = addr_a;
            rd_b_next = addr_b;
            tw_next   = tw_wide[2:0];
`ifdef FFT16_INVERSE_EN
            zangle_next = inv_reg ? angle_mag : (32'd0 - angle_mag);
`else
            zangle_next = 32'd0 - angle_mag;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            stage_reg  <= 2'd0;
            rd_en_reg  <= 1'b0;
            rd_a_reg   <= 4'd0;
            rd_b_reg   <= 4'd0;
            tw_reg     <= 3'd0;
            zangle_reg <= 32'd0;
        end else begin
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            stage_reg  <= stage_next;
            rd_en_reg  <= rd_en_next;
            rd_a_reg   <= rd_a_next;
            rd_b_reg   <= rd_b_next;
            tw_reg     <= tw_next;
            zangle_reg <= zangle_next;
        end
    end

    // Write-back delay line: BF_LAT registers of {valid, addr_a, addr_b}, free-running
    logic       dl_valid_reg [BF_LAT];
    logic [3:0] dl_a_reg     [BF_LAT];
    logic [3:0] dl_b_reg     [BF_LAT];

    generate
        for (genvar gi = 0; gi < BF_LAT; gi++) begin : g_dly
            logic       in_valid;
            logic [3:0] in_a, in_b;
            if (gi == 0) begin : g_head
                assign in_valid = rd_en_reg;
                assign in_a     = rd_a_reg;
                assign in_b     = rd_b_reg;
            end else begin : g_tail
                assign in_valid = dl_valid_reg[gi-1];
                assign in_a     = dl_a_reg[gi-1];
                assign in_b     = dl_b_reg[gi-1];
            end
            always_ff @(posedge clock) begin
                if (reset) begin
                    dl_valid_reg[gi] <= 1'b0;
                    dl_a_reg[gi]     <= 4'd0;
                    dl_b_reg[gi]     <= 4'd0;
                end else begin
                    dl_valid_reg[gi] <= in_valid;
                    dl_a_reg[gi]     <= in_a;
                    dl_b_reg[gi]     <= in_b;
                end
            end
        end
    endgenerate

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign stage     = stage_reg;
    assign rd_en     = rd_en_reg;
    assign rd_addr_a = rd_a_reg;
    assign rd_addr_b = rd_b_reg;
    assign tw_idx    = tw_reg;
    assign zangle    = zangle_reg;
    assign wr_en     = dl_valid_reg[BF_LAT-1];
    assign wr_addr_a = dl_a_reg[BF_LAT-1];
    assign wr_addr_b = dl_b_reg[BF_LAT-1];

endmodule

// File: tb/tb_fft16_bfly_sched.sv
// Directed bench for fft16_bfly_sched: BF_LAT=1 and BF_LAT=3 instances sharing clock, reset and start.
module tb_fft16_bfly_sched;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic inverse = 1'b0;

    logic        busy_1, done_1, rd_en_1, wr_en_1;
    logic [1:0]  stage_1;
    logic [3:0]  rd_addr_a_1, rd_addr_b_1, wr_addr_a_1, wr_addr_b_1;
    logic [2:0]  tw_idx_1;
    logic [31:0] zangle_1;

    logic        busy_3, done_3, rd_en_3, wr_en_3;
    logic [1:0]  stage_3;
    logic [3:0]  rd_addr_a_3, rd_addr_b_3, wr_addr_a_3, wr_addr_b_3;
    logic [2:0]  tw_idx_3;
    logic [31:0] zangle_3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    fft16_bfly_sched #(.BF_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .start(start),
`ifdef FFT16_INVERSE_EN
        .inverse(inverse),
`endif
        .busy(busy_1), .done(done_1), .stage(stage_1), .rd_en(rd_en_1),
        .rd_addr_a(rd_addr_a_1), .rd_addr_b(rd_addr_b_1), .tw_idx(tw_idx_1),
        .zangle(zangle_1), .wr_en(wr_en_1), .wr_addr_a(wr_addr_a_1), .wr_addr_b(wr_addr_b_1)
    );

    fft16_bfly_sched #(.BF_LAT(3)) dut3 (
        .clock(clock), .reset(reset), .start(start),
`ifdef FFT16_INVERSE_EN
        .inverse(inverse),
`endif
        .busy(busy_3), .done(done_3), .stage(stage_3), .rd_en(rd_en_3),
        .rd_addr_a(rd_addr_a_3), .rd_addr_b(rd_addr_b_3), .tw_idx(tw_idx_3),
        .zangle(zangle_3), .wr_en(wr_en_3), .wr_addr_a(wr_addr_a_3), .wr_addr_b(wr_addr_b_3)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({busy_1, done_1, rd_en_1, wr_en_1, stage_1} !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b exp 000000", {busy_1, done_1, rd_en_1, wr_en_1, stage_1});
        end
        n_cmp++;
        if ({rd_addr_a_1, rd_addr_b_1, tw_idx_1, wr_addr_a_1, wr_addr_b_1} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_addr got %h exp 0", {rd_addr_a_1, rd_addr_b_1, tw_idx_1, wr_addr_a_1, wr_addr_b_1});
        end
        n_cmp++;
        if (zangle_1 !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_zangle got %h exp 00000000", zangle_1);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (busy_1 !== 1'b0 || busy_3 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wins got busy %b/%b exp 0/0", busy_1, busy_3);
        end
        $display("test_reset done");
    endtask

    task automatic test_full_run();
        int rd_cnt, wr_cnt, s, k, span;
        logic exp_rd, exp_wr, prev_rd;
        logic [3:0] ea, eb, pa, pb;
        logic [2:0] etw;
        logic [31:0] ez;
        rd_cnt = 0; wr_cnt = 0; prev_rd = 1'b0; pa = 4'd0; pb = 4'd0;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy_1 !== 1'b0 || rd_en_1 !== 1'b0) begin
            n_bad++;
            $display("FAIL run1_t0 got busy %b rd %b exp 0 0", busy_1, rd_en_1);
        end
        for (int c = 1; c <= 40; c++) begin
            tick();
            exp_rd = (c >= 1 && c <= 36 && ((c - 1) % 9) < 8);
            exp_wr = prev_rd;
            s = (c - 1) / 9;
            k = (c - 1) % 9;
            span = 1 << (s % 4);
            ea = 4'((k / span) * 2 * span + (k % span));
            eb = 4'((k / span) * 2 * span + (k % span) + span);
            etw = 3'((k % span) * (8 / span));
            ez = 32'(-(int'(etw) * 268435456));
            if (rd_en_1 === 1'b1) rd_cnt++;
            if (wr_en_1 === 1'b1) wr_cnt++;
            n_cmp++;
            if (rd_en_1 !== exp_rd || wr_en_1 !== exp_wr) begin
                n_bad++;
                $display("FAIL run1_strobes c=%0d got rd %b wr %b exp rd %b wr %b", c, rd_en_1, wr_en_1, exp_rd, exp_wr);
            end
            n_cmp++;
            if (busy_1 !== (c <= 36) || done_1 !== (c == 37)) begin
                n_bad++;
                $display("FAIL run1_busy_done c=%0d got busy %b done %b exp %b %b", c, busy_1, done_1, c <= 36, c == 37);
            end
            if (exp_rd) begin
                n_cmp++;
                if (rd_addr_a_1 !== ea || rd_addr_b_1 !== eb || tw_idx_1 !== etw || zangle_1 !== ez || stage_1 !== 2'(s)) begin
                    n_bad++;
                    $display("FAIL run1_issue c=%0d got s%0d a%0d b%0d tw%0d z%h exp s%0d a%0d b%0d tw%0d z%h",
                             c, stage_1, rd_addr_a_1, rd_addr_b_1, tw_idx_1, zangle_1, s, ea, eb, etw, ez);
                end
            end
            if (exp_wr) begin
                n_cmp++;
                if (wr_addr_a_1 !== pa || wr_addr_b_1 !== pb) begin
                    n_bad++;
                    $display("FAIL run1_wb c=%0d got a%0d b%0d exp a%0d b%0d", c, wr_addr_a_1, wr_addr_b_1, pa, pb);
                end
            end
            if (c == 1) begin
                n_cmp++;
                if (rd_addr_a_1 !== 4'd0 || rd_addr_b_1 !== 4'd1 || zangle_1 !== 32'd0 || busy_1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL first_bfly got a%0d b%0d z%h busy %b exp a0 b1 z00000000 busy 1", rd_addr_a_1, rd_addr_b_1, zangle_1, busy_1);
                end
            end
            if (c == 11) begin
                n_cmp++;
                if (rd_addr_a_1 !== 4'd1 || rd_addr_b_1 !== 4'd3 || tw_idx_1 !== 3'd4 || zangle_1 !== 32'hC000_0000) begin
                    n_bad++;
                    $display("FAIL s1k1 got a%0d b%0d tw%0d z%h exp a1 b3 tw4 zc0000000", rd_addr_a_1, rd_addr_b_1, tw_idx_1, zangle_1);
                end
            end
            if (c == 35) begin
                n_cmp++;
                if (rd_addr_a_1 !== 4'd7 || rd_addr_b_1 !== 4'd15 || tw_idx_1 !== 3'd7 || zangle_1 !== 32'h9000_0000) begin
                    n_bad++;
                    $display("FAIL s3k7 got a%0d b%0d tw%0d z%h exp a7 b15 tw7 z90000000", rd_addr_a_1, rd_addr_b_1, tw_idx_1, zangle_1);
                end
            end
            prev_rd = exp_rd;
            pa = ea;
            pb = eb;
        end
        n_cmp++;
        if (rd_cnt != 32 || wr_cnt != 32) begin
            n_bad++;
            $display("FAIL run1_counts got rd %0d wr %0d exp 32 32", rd_cnt, wr_cnt);
        end
        $display("test_full_run done: rd %0d wr %0d", rd_cnt, wr_cnt);
    endtask

    task automatic test_bflat3();
        int rd_cnt, wr_cnt, last_wr, cw, s, k, span;
        logic exp_rd, exp_wr;
        logic [3:0] ea, eb;
        rd_cnt = 0; wr_cnt = 0; last_wr = -1;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            tick();
            exp_rd = (c <= 44 && ((c - 1) % 11) < 8);
            cw = c - 3;
            exp_wr = (cw >= 1 && cw <= 44 && ((cw - 1) % 11) < 8);
            s = (cw - 1) / 11;
            k = (cw - 1) % 11;
            span = 1 << (s % 4);
            ea = 4'((k / span) * 2 * span + (k % span));
            eb = 4'((k / span) * 2 * span + (k % span) + span);
            if (rd_en_3 === 1'b1) rd_cnt++;
            if (wr_en_3 === 1'b1) begin
                wr_cnt++;
                last_wr = c;
            end
            n_cmp++;
            if (rd_en_3 !== exp_rd || wr_en_3 !== exp_wr) begin
                n_bad++;
                $display("FAIL lat3_strobes c=%0d got rd %b wr %b exp rd %b wr %b", c, rd_en_3, wr_en_3, exp_rd, exp_wr);
            end
            n_cmp++;
            if (busy_3 !== (c <= 44) || done_3 !== (c == 45)) begin
                n_bad++;
                $display("FAIL lat3_busy_done c=%0d got busy %b done %b exp %b %b", c, busy_3, done_3, c <= 44, c == 45);
            end
            if (exp_wr) begin
                n_cmp++;
                if (wr_addr_a_3 !== ea || wr_addr_b_3 !== eb) begin
                    n_bad++;
                    $display("FAIL lat3_wb c=%0d got a%0d b%0d exp a%0d b%0d", c, wr_addr_a_3, wr_addr_b_3, ea, eb);
                end
            end
        end
        n_cmp++;
        if (rd_cnt != 32 || wr_cnt != 32 || last_wr != 44) begin
            n_bad++;
            $display("FAIL lat3_counts got rd %0d wr %0d last_wr %0d exp 32 32 44", rd_cnt, wr_cnt, last_wr);
        end
        $display("test_bflat3 done: rd %0d wr %0d last_wr %0d", rd_cnt, wr_cnt, last_wr);
    endtask

    task automatic test_reset_mid();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 22; c++) tick();
        n_cmp++;
        if (rd_en_1 !== 1'b1 || stage_1 !== 2'd2 || rd_addr_a_1 !== 4'd3 || rd_addr_b_1 !== 4'd7) begin
            n_bad++;
            $display("FAIL mid_pre got rd %b s%0d a%0d b%0d exp 1 s2 a3 b7", rd_en_1, stage_1, rd_addr_a_1, rd_addr_b_1);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({busy_1, rd_en_1, wr_en_1, done_1, busy_3, rd_en_3, wr_en_3} !== 7'd0) begin
            n_bad++;
            $display("FAIL mid_reset got %b exp 0000000", {busy_1, rd_en_1, wr_en_1, done_1, busy_3, rd_en_3, wr_en_3});
        end
        reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (wr_en_1 !== 1'b0 || wr_en_3 !== 1'b0 || busy_1 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_flush got wr %b/%b busy %b exp 0/0 0", wr_en_1, wr_en_3, busy_1);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (rd_en_1 !== 1'b1 || stage_1 !== 2'd0 || rd_addr_a_1 !== 4'd0 || rd_addr_b_1 !== 4'd1 || wr_en_1 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_restart got rd %b s%0d a%0d b%0d wr %b exp 1 s0 a0 b1 0", rd_en_1, stage_1, rd_addr_a_1, rd_addr_b_1, wr_en_1);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        inverse = 1'b0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 76; c++) begin
            tick();
            if (c == 20) begin
                n_cmp++;
                if (busy_1 !== 1'b1 || stage_1 !== 2'd2 || rd_addr_a_1 !== 4'd1 || rd_addr_b_1 !== 4'd5) begin
                    n_bad++;
                    $display("FAIL b2b_norestart got busy %b s%0d a%0d b%0d exp 1 s2 a1 b5", busy_1, stage_1, rd_addr_a_1, rd_addr_b_1);
                end
            end
            if (c == 37) begin
                n_cmp++;
                if (done_1 !== 1'b1 || busy_1 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_done1 got done %b busy %b exp 1 0", done_1, busy_1);
                end
                inverse = 1'b1;
            end
            if (c == 38) begin
                n_cmp++;
                if (busy_1 !== 1'b0 || rd_en_1 !== 1'b0 || done_1 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_idle got busy %b rd %b done %b exp 0 0 0", busy_1, rd_en_1, done_1);
                end
            end
            if (c == 39) begin
                n_cmp++;
                if (busy_1 !== 1'b1 || rd_en_1 !== 1'b1 || stage_1 !== 2'd0 || rd_addr_a_1 !== 4'd0 || rd_addr_b_1 !== 4'd1) begin
                    n_bad++;
                    $display("FAIL b2b_second got busy %b rd %b s%0d a%0d b%0d exp 1 1 s0 a0 b1", busy_1, rd_en_1, stage_1, rd_addr_a_1, rd_addr_b_1);
                end
            end
            if (c == 67) begin
                n_cmp++;
`ifdef FFT16_INVERSE_EN
                if (zangle_1 !== 32'h1000_0000 || tw_idx_1 !== 3'd1) begin
                    n_bad++;
                    $display("FAIL b2b_s3k1 got tw%0d z%h exp tw1 z10000000", tw_idx_1, zangle_1);
                end
`else
                if (zangle_1 !== 32'hF000_0000 || tw_idx_1 !== 3'd1) begin
                    n_bad++;
                    $display("FAIL b2b_s3k1 got tw%0d z%h exp tw1 zf0000000", tw_idx_1, zangle_1);
                end
`endif
                start = 1'b0;
            end
            if (c == 75) begin
                n_cmp++;
                if (done_1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_done2 got done %b exp 1", done_1);
                end
            end
            if (c == 76) begin
                n_cmp++;
                if (busy_1 !== 1'b0 || done_1 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_end got busy %b done %b exp 0 0", busy_1, done_1);
                end
            end
        end
        inverse = 1'b0;
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_bflat3();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
